// File: rtl/aes_pipe_sched.sv
// Round-robin scheduler and key controller that shares one pipelined AES-128 core among NREQ requesters.
// A {valid,id} tag pipe that matches the core latency routes each ciphertext back to the requester that issued it.
module aes_pipe_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 11,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*128-1:0]   req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [127:0]          key_in,
    input  logic                  key_load_valid,
    output logic                  key_load_ready,
    output logic [127:0]          aes_state,
    output logic [127:0]          aes_key,
    input  logic [127:0]          aes_out,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [127:0]          rsp_data,
    output logic                  busy
);
    localparam int IW = (IDW < 1) ? 1 : IDW;
    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_issue_id;
    logic            r_issue_v;
    logic [LAT-1:0]  r_tag_v;
    logic [IW-1:0]   r_tag_id [LAT];
    logic [CW-1:0]   r_inflight;

    logic [IW-1:0]   w_gid;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic            w_grant_ok;
    logic            w_xfer;
    logic [127:0]    w_req_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_req_arr[gi] = req_data[128*gi +: 128];
            assign req_ready[gi] = w_xfer && (w_gid == IW'(gi));
            assign rsp_valid[gi] = r_tag_v[LAT-1] && (r_tag_id[LAT-1] == IW'(gi));
        end
    endgenerate

    // Search starts one past the last winner, so a lone requester can win back-to-back.
    always_comb begin
        w_found = 1'b0;
        w_gid   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (key_load_valid) w_state_next = DRAIN;
            DRAIN:   if (r_inflight == '0) w_state_next = LOAD;
            LOAD:    w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_grant_ok     = (r_state == RUN) && !key_load_valid && !rst;
        key_load_ready = (r_state == LOAD);
        busy           = (r_inflight != '0) || (r_state != RUN);
    end

    assign w_xfer   = w_grant_ok && w_found;
    assign rsp_data = aes_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= IW'(NREQ - 1);
            r_issue_v  <= 1'b0;
            r_issue_id <= '0;
            aes_state  <= '0;
        end else begin
            r_issue_v <= w_xfer;
            if (w_xfer) begin
                r_issue_id <= w_gid;
                r_ptr      <= w_gid;
                aes_state  <= w_req_arr[w_gid];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aes_key <= '0;
        end else if (r_state == LOAD) begin
            aes_key <= key_in;
        end
    end

    // Tag pipe never stalls: it tracks the core's fixed latency one-for-one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_tag_v[0]  <= r_issue_v;
            r_tag_id[0] <= r_issue_id;
            for (int k = 1; k < LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Counted from the accept edge until the result leaves the last tag stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, r_tag_v[LAT-1]})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_pipe_sched.sv
// Randomised bench for aes_pipe_sched: a stand-in keyed transform with LAT-cycle latency plays the AES core,
// and a queue-based model predicts grants, key handshakes, busy and every routed response.
module tb_aes_pipe_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 11;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic [127:0]        key_in;
    logic                key_load_valid;
    logic                key_load_ready;
    logic [127:0]        aes_state;
    logic [127:0]        aes_key;
    logic [127:0]        aes_out;
    logic [NREQ-1:0]     rsp_valid;
    logic [127:0]        rsp_data;
    logic                busy;

    aes_pipe_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .key_in(key_in), .key_load_valid(key_load_valid), .key_load_ready(key_load_ready),
        .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mix(input logic [127:0] s, input logic [127:0] k);
        return {s[62:0], s[127:63]} ^ k ^ 128'h5a3c_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;
    endfunction

    logic [127:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= mix(aes_state, aes_key);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign aes_out = apipe[LAT-1];

    typedef struct {
        int           due;
        int           id;
        logic [127:0] data;
    } exp_t;

    exp_t            q[$];
    exp_t            e;
    int              glog[$];
    int              m_mode;
    int              m_ptr;
    logic [127:0]    m_key;
    logic [127:0]    m_state;
    int              cyc = 0;
    int              n_vec = 0;
    int              n_err = 0;
    int              klr_cnt = 0;
    int              g;
    int              qsz;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rsp;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: modes 0=issuing, 1=waiting for empty pipe, 2=key load; in-flight blocks live in q.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_mode  = 0;
            m_ptr   = NREQ - 1;
            m_key   = '0;
            m_state = '0;
            chk("rst_req_ready", 128'(req_ready), '0);
            chk("rst_rsp_valid", 128'(rsp_valid), '0);
            chk("rst_key_load_ready", 128'(key_load_ready), '0);
            chk("rst_busy", 128'(busy), '0);
            chk("rst_aes_key", aes_key, '0);
            chk("rst_aes_state", aes_state, '0);
        end else begin
            qsz     = q.size();
            g       = -1;
            exp_rdy = '0;
            if (m_mode == 0 && !key_load_valid) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("key_load_ready", 128'(key_load_ready), 128'(m_mode == 2));
            chk("busy", 128'(busy), 128'((qsz != 0) || (m_mode != 0)));
            chk("aes_key", aes_key, m_key);
            chk("aes_state", aes_state, m_state);
            exp_rsp = '0;
            if (qsz > 0 && q[0].due == cyc) begin
                exp_rsp[q[0].id] = 1'b1;
                chk("rsp_data", rsp_data, q[0].data);
                $display("rsp req%0d data %h cycle %0d", q[0].id, rsp_data, cyc);
                void'(q.pop_front());
            end
            chk("rsp_valid", 128'(rsp_valid), 128'(exp_rsp));
            if (key_load_ready) klr_cnt++;
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k] && req_valid[k]) glog.push_back(k);
            end
            if (g >= 0) begin
                e.due  = cyc + 1 + LAT;
                e.id   = g;
                e.data = mix(req_data[g*128 +: 128], m_key);
                q.push_back(e);
                m_state = req_data[g*128 +: 128];
                m_ptr   = g;
            end
            case (m_mode)
                0: if (key_load_valid) m_mode = 1;
                1: if (qsz == 0) m_mode = 2;
                default: begin
                    m_key  = key_in;
                    m_mode = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int k = 0; k < NREQ; k++) req_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_klr();
        int t;
        t = 0;
        @(negedge clk);
        while (!key_load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!key_load_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL key_load_timeout: got no key_load_ready expected pulse within 100 cycles");
        end
        @(posedge clk);
        #1 key_load_valid = 1'b0;
    endtask

    int bc;
    int kc;
    int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int sp_exp[4] = '{1, 3, 1, 3};

    initial begin
        req_valid = '0;
        req_data = '0;
        key_in = '0;
        key_load_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        key_in = 128'he4dc18adf3d05ec9e4dcc41acb990007;
        key_load_valid = 1'b1;
        wait_klr();

        glog.delete();
        repeat (8) begin
            set_req('1);
            tick();
        end
        set_req('0);
        chki("rr_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) chki("rr_order", glog[i], rr_exp[i]);
        repeat (LAT + 3) tick();

        glog.delete();
        req_valid = 4'b0001;
        req_data[127:0] = 128'h4072da1240f930f7d3c8cf8b9322042e;
        tick();
        req_data[127:0] = 128'h110687e2636afdb84c12653d55f3bae1;
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        chki("single_count", glog.size(), 2);

        glog.delete();
        repeat (4) begin
            set_req(4'b1010);
            tick();
        end
        set_req('0);
        chki("sparse_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) chki("sparse_order", glog[i], sp_exp[i]);
        repeat (LAT + 3) tick();

        bc = 0;
        set_req(4'b0100);
        @(negedge clk);
        if (busy) bc++;
        @(posedge clk);
        #1 set_req('0);
        repeat (30) begin
            @(negedge clk);
            if (busy) bc++;
        end
        @(posedge clk);
        #1;
        chki("busy_width", bc, LAT + 1);

        glog.delete();
        kc = klr_cnt;
        repeat (5) begin
            set_req('1);
            tick();
        end
        chki("grants_before_key", glog.size(), 5);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        key_load_valid = 1'b1;
        wait_klr();
        @(negedge clk);
        chk("grant_after_load", 128'(|(req_ready & req_valid)), 128'(1'b1));
        repeat (6) begin
            @(posedge clk);
            #1 set_req('1);
        end
        tick();
        set_req('0);
        repeat (LAT + 3) tick();
        chki("klr_pulses", klr_cnt - kc, 1);

        repeat (3) begin
            set_req('1);
            tick();
        end
        set_req('0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 128'(rsp_valid), '0);
            chk("post_rst_busy", 128'(busy), '0);
        end
        @(posedge clk);
        #1;
        chk("post_rst_aes_key", aes_key, '0);
        set_req('1);
        @(negedge clk);
        chk("first_grant_after_rst", 128'(req_ready), 128'(4'b0001));
        @(posedge clk);
        #1 set_req('0);

        for (int i = 0; i < 300; i++) begin
            set_req(NREQ'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                key_in = {$urandom, $urandom, $urandom, $urandom};
                key_load_valid = 1'b1;
                wait_klr();
            end else begin
                tick();
            end
        end
        set_req('0);
        repeat (LAT + 4) tick();
        chki("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
